serial_bus_master_port: RTL and testbench

- Parametrised bit-serial bus master interface; next generation of the top-level master port.
- Accepts parallel read/write requests from a local master (address, data, R/W, execute, hold).
- Obtains the bus from the arbiter, then serialises address and data LSB-first.
- Adds configurable widths, slave SPLIT handling, ACK timeout with error reporting, and bus retention (hold) across back-to-back transactions.

---
 rtl/serial_bus_master_port.sv | 234 +++++++++++++++++++++++
 tb/tb_serial_bus_master_port.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master_port.sv
// Bit-serial bus master port: takes parallel read/write requests, wins the bus,
// then shifts address and data LSB-first with ACK timeout, SPLIT and bus hold.
module serial_bus_master_port #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              M_EXECUTE,
   input  logic              M_RW,
   input  logic [ADDR_W-1:0] M_ADDR,
   input  logic [DATA_W-1:0] M_DIN,
   input  logic              M_HOLD,
   output logic [DATA_W-1:0] M_DOUT,
   output logic              M_DVALID,
   output logic              M_BSY,
   output logic              M_ERR,
   output logic              B_REQ,
   input  logic              B_GRANT,
   output logic              B_BUS_OUT,
   output logic              B_VALID,
   output logic              B_MODE,
   output logic              B_RW,
   input  logic              B_BUS_IN,
   input  logic              B_SVALID,
   input  logic              B_ACK,
   input  logic              B_SPLIT
);

   localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int MAX_ALL = (MAX_AD > TIMEOUT) ? MAX_AD : TIMEOUT;
   localparam int CW      = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_ADDR, S_AACK, S_SPLIT,
      S_WDATA, S_WACK, S_RDATA, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rw_q, rw_d;
   logic              hold_q, hold_d;
   logic              b_req_q, b_req_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic              tmo_hit;
   logic [DATA_W-1:0] rx_word;

   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case leaves
      // a variable unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      din_d     = din_q;
      rdata_d   = rdata_q;
      dout_d    = dout_q;
      rw_d      = rw_q;
      hold_d    = hold_q;
      b_req_d   = b_req_q;
      bit_cnt_d = bit_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      rx_word   = rdata_q | (DATA_W'(B_BUS_IN) << bit_cnt_q);

      unique case (state_q)
         S_IDLE: begin
            if (M_EXECUTE) begin
               addr_d    = M_ADDR;
               din_d     = M_DIN;
               rw_d      = M_RW;
               hold_d    = M_HOLD;
               rdata_d   = '0;
               bit_cnt_d = '0;
               b_req_d   = 1'b1;
               // A retained bus that is still granted skips arbitration.
               state_d   = (b_req_q && B_GRANT) ? S_ADDR : S_REQ;
            end else if (b_req_q && !M_HOLD) begin
               b_req_d = 1'b0;
            end
         end
         S_REQ: begin
            if (B_GRANT) begin
               bit_cnt_d = '0;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (!B_GRANT) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else if (bit_cnt_q == ADDR_LAST) begin
               tmo_cnt_d = '0;
               state_d   = S_AACK;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         S_AACK: begin
            if (!B_GRANT) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else if (!rw_q && B_SPLIT) begin
               b_req_d = 1'b0;
               state_d = S_SPLIT;
            end else if (B_ACK) begin
               bit_cnt_d = '0;
               tmo_cnt_d = '0;
               state_d   = rw_q ? S_WDATA : S_RDATA;
            end else if (tmo_hit) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end
         S_SPLIT: begin
            // Request was dropped on entry; only a grant after re-request counts.
            b_req_d = 1'b1;
            if (b_req_q && B_GRANT) begin
               bit_cnt_d = '0;
               tmo_cnt_d = '0;
               state_d   = S_RDATA;
            end
         end
         S_WDATA: begin
            if (!B_GRANT) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else if (bit_cnt_q == DATA_LAST) begin
               tmo_cnt_d = '0;
               state_d   = S_WACK;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         S_WACK: begin
            if (!B_GRANT) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else if (B_ACK) begin
               state_d = S_DONE;
            end else if (tmo_hit) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end
         S_RDATA: begin
            if (!B_GRANT) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else if (B_SVALID) begin
               rdata_d   = rx_word;
               tmo_cnt_d = '0;
               if (bit_cnt_q == DATA_LAST) begin
                  dout_d  = rx_word;
                  state_d = S_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end else if (tmo_hit) begin
               b_req_d = 1'b0;
               state_d = S_ERR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            b_req_d = hold_q;
            state_d = S_IDLE;
         end
         S_ERR: begin
            b_req_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values; the data registers are reset too so outputs read 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         din_q     <= '0;
         rdata_q   <= '0;
         dout_q    <= '0;
         rw_q      <= 1'b0;
         hold_q    <= 1'b0;
         b_req_q   <= 1'b0;
         bit_cnt_q <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         rdata_q   <= rdata_d;
         dout_q    <= dout_d;
         rw_q      <= rw_d;
         hold_q    <= hold_d;
         b_req_q   <= b_req_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   logic addr_bit, data_bit;
   assign addr_bit = |(addr_q & (ADDR_W'(1) << bit_cnt_q));
   assign data_bit = |(din_q & (DATA_W'(1) << bit_cnt_q));

   assign M_DOUT    = dout_q;
   assign M_DVALID  = (state_q == S_DONE);
   assign M_ERR     = (state_q == S_ERR);
   assign M_BSY     = (state_q != S_IDLE);
   assign B_REQ     = b_req_q;
   assign B_VALID   = (state_q == S_ADDR) || (state_q == S_WDATA);
   assign B_MODE    = (state_q == S_WDATA);
   assign B_BUS_OUT = (state_q == S_ADDR)  ? addr_bit :
                      (state_q == S_WDATA) ? data_bit : 1'b0;
   assign B_RW      = rw_q && (state_q inside {S_ADDR, S_AACK, S_SPLIT, S_WDATA,
                                               S_WACK, S_RDATA, S_DONE});

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Self-checking bench for serial_bus_master_port: directed vectors plus random
// transactions compared against a transaction-level reference model.
module tb_serial_bus_master_port;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 32;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              M_EXECUTE = 1'b0;
   logic              M_RW = 1'b0;
   logic [ADDR_W-1:0] M_ADDR = '0;
   logic [DATA_W-1:0] M_DIN = '0;
   logic              M_HOLD = 1'b0;
   logic [DATA_W-1:0] M_DOUT;
   logic              M_DVALID, M_BSY, M_ERR, B_REQ;
   logic              B_GRANT = 1'b0;
   logic              B_BUS_OUT, B_VALID, B_MODE, B_RW;
   logic              B_BUS_IN = 1'b0;
   logic              B_SVALID = 1'b0;
   logic              B_ACK = 1'b0;
   logic              B_SPLIT = 1'b0;

   serial_bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .M_EXECUTE(M_EXECUTE), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_HOLD(M_HOLD),
      .M_DOUT(M_DOUT), .M_DVALID(M_DVALID), .M_BSY(M_BSY), .M_ERR(M_ERR),
      .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_BUS_OUT(B_BUS_OUT), .B_VALID(B_VALID),
      .B_MODE(B_MODE), .B_RW(B_RW), .B_BUS_IN(B_BUS_IN), .B_SVALID(B_SVALID),
      .B_ACK(B_ACK), .B_SPLIT(B_SPLIT)
   );

   always #5 CLK = ~CLK;

   logic [DATA_W+7:0] outs;
   assign outs = {M_DOUT, M_DVALID, M_BSY, M_ERR, B_REQ, B_BUS_OUT, B_VALID, B_MODE, B_RW};

   int n_pass  = 0;
   int n_total = 0;
   // Reference model state: the last completed read value M_DOUT must show.
   logic [DATA_W-1:0] last_read = '0;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start(input logic rw, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic hold);
      M_EXECUTE = 1'b1;
      M_RW      = rw;
      M_ADDR    = a;
      M_DIN     = d;
      M_HOLD    = hold;
      tick();
      M_EXECUTE = 1'b0;
   endtask

   // Records n serial cycles: bit i of 'bits' is B_BUS_OUT in cycle i.
   task automatic collect(input int n, output logic [31:0] bits,
                          output int vcnt, output int mcnt);
      bits = '0;
      vcnt = 0;
      mcnt = 0;
      for (int i = 0; i < n; i++) begin
         bits[i] = B_BUS_OUT;
         if (B_VALID === 1'b1) vcnt++;
         if (B_MODE === 1'b1) mcnt++;
         tick();
      end
   endtask

   task automatic send_read(input logic [DATA_W-1:0] val, input int gap);
      for (int k = 0; k < DATA_W; k++) begin
         if (k > 0) repeat (gap) tick();
         B_SVALID = 1'b1;
         B_BUS_IN = val[k];
         tick();
         B_SVALID = 1'b0;
         B_BUS_IN = 1'b0;
      end
   endtask

   task automatic run_txn(input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd,
                          input int gdly, input int adly, input int gap,
                          output logic [31:0] a_obs, output logic [31:0] d_obs,
                          output logic dv, output logic er,
                          output logic [DATA_W-1:0] dout_obs);
      int v, m;
      start(rw, a, d, 1'b0);
      repeat (gdly) tick();
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, a_obs, v, m);
      repeat (adly) tick();
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      if (rw) begin
         collect(DATA_W, d_obs, v, m);
         repeat (adly) tick();
         B_ACK = 1'b1;
         tick();
         B_ACK = 1'b0;
      end else begin
         d_obs = '0;
         send_read(rd, gap);
      end
      dv       = M_DVALID;
      er       = M_ERR;
      dout_obs = M_DOUT;
      tick();
      B_GRANT = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      n_total++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
      else n_pass++;
      RST = 1'b0;
      last_read = '0;
      tick();
      n_total++;
      if (outs !== '0) $display("FAIL idle_outputs: got %h expected 0", outs);
      else n_pass++;
   endtask

   task automatic test_write_vector();
      logic [31:0] bits;
      int v, m;
      start(1'b1, 16'hA5C3, 8'hAD, 1'b0);
      n_total++;
      if ({B_REQ, M_BSY, B_VALID} !== 3'b110)
         $display("FAIL wr_req_bsy: got %b expected 110", {B_REQ, M_BSY, B_VALID});
      else n_pass++;
      tick();
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, bits, v, m);
      n_total++;
      if (bits[ADDR_W-1:0] !== 16'hA5C3 || v != ADDR_W || m != 0)
         $display("FAIL wr_addr_stream: got %h v=%0d m=%0d expected a5c3 v=%0d m=0",
                  bits[ADDR_W-1:0], v, m, ADDR_W);
      else n_pass++;
      tick();
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      collect(DATA_W, bits, v, m);
      n_total++;
      if (bits[DATA_W-1:0] !== 8'hAD || v != DATA_W || m != DATA_W)
         $display("FAIL wr_data_stream: got %h v=%0d m=%0d expected ad v=%0d m=%0d",
                  bits[DATA_W-1:0], v, m, DATA_W, DATA_W);
      else n_pass++;
      n_total++;
      if (B_VALID !== 1'b0) $display("FAIL wack_valid: got %b expected 0", B_VALID);
      else n_pass++;
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      n_total++;
      if ({M_DVALID, M_ERR, B_RW} !== 3'b101)
         $display("FAIL wr_done: got %b expected 101", {M_DVALID, M_ERR, B_RW});
      else n_pass++;
      tick();
      n_total++;
      if ({M_DVALID, M_BSY, B_REQ} !== 3'b000)
         $display("FAIL wr_after_done: got %b expected 000", {M_DVALID, M_BSY, B_REQ});
      else n_pass++;
      B_GRANT = 1'b0;
   endtask

   task automatic test_read_vector();
      logic [31:0] bits;
      int v, m;
      start(1'b0, 16'h0042, 8'h00, 1'b0);
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, bits, v, m);
      n_total++;
      if (bits[ADDR_W-1:0] !== 16'h0042)
         $display("FAIL rd_addr_stream: got %h expected 0042", bits[ADDR_W-1:0]);
      else n_pass++;
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      send_read(8'h5B, 1);
      last_read = 8'h5B;
      n_total++;
      if ({M_DVALID, M_DOUT} !== {1'b1, last_read})
         $display("FAIL rd_done: got dv=%b dout=%h expected dv=1 dout=%h", M_DVALID, M_DOUT, last_read);
      else n_pass++;
      tick();
      n_total++;
      if ({M_DVALID, M_BSY, M_DOUT} !== {2'b00, last_read})
         $display("FAIL rd_after_done: got dv=%b bsy=%b dout=%h expected 0 0 %h",
                  M_DVALID, M_BSY, M_DOUT, last_read);
      else n_pass++;
      B_GRANT = 1'b0;
   endtask

   task automatic test_split();
      logic [31:0] bits;
      logic [ADDR_W-1:0] a;
      int v, m, bad;
      a = ADDR_W'($urandom);
      start(1'b0, a, 8'h00, 1'b0);
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, bits, v, m);
      n_total++;
      if (bits[ADDR_W-1:0] !== a)
         $display("FAIL split_addr: got %h expected %h", bits[ADDR_W-1:0], a);
      else n_pass++;
      B_SPLIT = 1'b1;
      B_ACK   = 1'b1;
      tick();
      B_SPLIT = 1'b0;
      B_ACK   = 1'b0;
      B_GRANT = 1'b0;
      n_total++;
      if ({B_REQ, M_BSY} !== 2'b01)
         $display("FAIL split_req_drop: got %b expected 01", {B_REQ, M_BSY});
      else n_pass++;
      tick();
      n_total++;
      if ({B_REQ, M_BSY} !== 2'b11)
         $display("FAIL split_req_again: got %b expected 11", {B_REQ, M_BSY});
      else n_pass++;
      bad = 0;
      repeat (20) begin
         tick();
         if (M_BSY !== 1'b1 || B_REQ !== 1'b1 || B_VALID !== 1'b0 || M_DVALID !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL split_wait: got %0d bad cycles expected 0", bad);
      else n_pass++;
      B_GRANT = 1'b1;
      tick();
      send_read(8'hC7, 0);
      last_read = 8'hC7;
      n_total++;
      if ({M_DVALID, M_DOUT} !== {1'b1, last_read})
         $display("FAIL split_done: got dv=%b dout=%h expected dv=1 dout=%h", M_DVALID, M_DOUT, last_read);
      else n_pass++;
      tick();
      B_GRANT = 1'b0;
   endtask

   task automatic test_timeout();
      logic [31:0] bits;
      int v, m, cycles;
      logic seen_dv;
      start(1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'b0);
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, bits, v, m);
      cycles  = 0;
      seen_dv = 1'b0;
      while (M_ERR !== 1'b1 && cycles < 3 * TIMEOUT) begin
         tick();
         cycles++;
         if (M_DVALID === 1'b1) seen_dv = 1'b1;
      end
      n_total++;
      if (cycles != TIMEOUT)
         $display("FAIL timeout_latency: got %0d cycles expected %0d", cycles, TIMEOUT);
      else n_pass++;
      n_total++;
      if ({B_REQ, seen_dv, M_DVALID} !== 3'b000)
         $display("FAIL timeout_err_state: got %b expected 000", {B_REQ, seen_dv, M_DVALID});
      else n_pass++;
      tick();
      n_total++;
      if ({M_ERR, M_BSY, B_REQ} !== 3'b000)
         $display("FAIL timeout_after: got %b expected 000", {M_ERR, M_BSY, B_REQ});
      else n_pass++;
      B_GRANT = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] bits;
      logic [ADDR_W-1:0] a2;
      logic [DATA_W-1:0] d2;
      int v, m;
      a2 = ADDR_W'($urandom);
      d2 = DATA_W'($urandom);
      start(1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, bits, v, m);
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      collect(DATA_W, bits, v, m);
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      n_total++;
      if ({M_DVALID, B_REQ} !== 2'b11)
         $display("FAIL hold_done: got %b expected 11", {M_DVALID, B_REQ});
      else n_pass++;
      tick();
      n_total++;
      if ({M_BSY, B_REQ} !== 2'b01)
         $display("FAIL hold_idle: got %b expected 01", {M_BSY, B_REQ});
      else n_pass++;
      start(1'b1, a2, d2, 1'b0);
      n_total++;
      if ({B_VALID, B_MODE, B_REQ} !== 3'b101)
         $display("FAIL hold_direct_addr: got %b expected 101", {B_VALID, B_MODE, B_REQ});
      else n_pass++;
      collect(ADDR_W, bits, v, m);
      n_total++;
      if (bits[ADDR_W-1:0] !== a2)
         $display("FAIL hold_addr2: got %h expected %h", bits[ADDR_W-1:0], a2);
      else n_pass++;
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      collect(DATA_W, bits, v, m);
      n_total++;
      if (bits[DATA_W-1:0] !== d2)
         $display("FAIL hold_data2: got %h expected %h", bits[DATA_W-1:0], d2);
      else n_pass++;
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      tick();
      n_total++;
      if ({M_BSY, B_REQ} !== 2'b00)
         $display("FAIL hold_release: got %b expected 00", {M_BSY, B_REQ});
      else n_pass++;
      B_GRANT = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] bits, a_obs, d_obs;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, dout_obs;
      logic dv, er;
      int v, m;
      start(1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'b0);
      B_GRANT = 1'b1;
      tick();
      collect(ADDR_W, bits, v, m);
      B_ACK = 1'b1;
      tick();
      B_ACK = 1'b0;
      tick();
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      last_read = '0;
      n_total++;
      if (outs !== '0) $display("FAIL reset_mid_outputs: got %h expected 0", outs);
      else n_pass++;
      B_GRANT = 1'b0;
      tick();
      a = ADDR_W'($urandom);
      d = DATA_W'($urandom);
      run_txn(1'b1, a, d, '0, 1, 2, 0, a_obs, d_obs, dv, er, dout_obs);
      n_total++;
      if (a_obs[ADDR_W-1:0] !== a || d_obs[DATA_W-1:0] !== d || dv !== 1'b1 || er !== 1'b0)
         $display("FAIL reset_mid_recover: got a=%h d=%h dv=%b er=%b expected a=%h d=%h dv=1 er=0",
                  a_obs[ADDR_W-1:0], d_obs[DATA_W-1:0], dv, er, a, d);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a_obs, d_obs;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, rd, dout_obs;
      logic rw, dv, er;
      for (int t = 0; t < 10; t++) begin
         rw = 1'($urandom);
         a  = ADDR_W'($urandom);
         d  = DATA_W'($urandom);
         rd = DATA_W'($urandom);
         run_txn(rw, a, d, rd, $urandom_range(0, 4), $urandom_range(0, 6),
                 $urandom_range(0, 3), a_obs, d_obs, dv, er, dout_obs);
         if (!rw) last_read = rd;
         n_total++;
         if (a_obs[ADDR_W-1:0] !== a)
            $display("FAIL rand_addr[%0d]: got %h expected %h", t, a_obs[ADDR_W-1:0], a);
         else n_pass++;
         if (rw) begin
            n_total++;
            if (d_obs[DATA_W-1:0] !== d)
               $display("FAIL rand_wdata[%0d]: got %h expected %h", t, d_obs[DATA_W-1:0], d);
            else n_pass++;
         end
         n_total++;
         if ({dv, er, dout_obs} !== {2'b10, last_read})
            $display("FAIL rand_done[%0d]: got dv=%b er=%b dout=%h expected dv=1 er=0 dout=%h",
                     t, dv, er, dout_obs, last_read);
         else n_pass++;
         n_total++;
         if ({M_BSY, B_REQ, M_DVALID} !== 3'b000)
            $display("FAIL rand_idle[%0d]: got %b expected 000", t, {M_BSY, B_REQ, M_DVALID});
         else n_pass++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_vector();
      test_read_vector();
      test_split();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
